// File: rtl/host_uart_pkg.sv
// host_uart_pkg: shared types and constants for the host UART bridge.
//   rx_state_t : receiver FSM states (RX_IDLE, RX_START, RX_DATA, RX_STOP)
//   tx_state_t : transmitter FSM states (TX_IDLE, TX_LOAD, TX_SHIFT)
//   FRAME_BITS : start + data + stop bits of an 8N1 frame
//   DATA_BITS  : payload width
package host_uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Prefixed so both enums can live in one package without name clashes.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT
    } tx_state_t;

endpackage

// File: rtl/host_uart_bridge_if.sv
// host_uart_bridge_if: host-FIFO interface between the bridge and the bus master.
//   RDEN    : master pops one byte from the RX FIFO
//   RDEMPTY : RX FIFO empty
//   RDDATA  : popped byte, valid the cycle after RDEN
//   WREN    : master pushes WRDATA into the TX FIFO
//   WRFULL  : TX FIFO full
//   WRDATA  : byte to transmit
// Modports: master (bus master side), slave (bridge side).
interface host_uart_bridge_if;
    import host_uart_pkg::*;

    logic                 RDEN;
    logic                 RDEMPTY;
    logic [DATA_BITS-1:0] RDDATA;
    logic                 WREN;
    logic                 WRFULL;
    logic [DATA_BITS-1:0] WRDATA;

    modport master (
        output RDEN, WREN, WRDATA,
        input  RDEMPTY, RDDATA, WRFULL
    );

    modport slave (
        input  RDEN, WREN, WRDATA,
        output RDEMPTY, RDDATA, WRFULL
    );

endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with registered flags and registered output.
//   CLK, RESETn : clock, synchronous active-low reset (flushes the FIFO, dout=0)
//   push, din   : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   dout        : byte read by the last successful pop, held otherwise
//   empty, full : registered status flags
// Parameter DEPTH: number of entries, power of 2, at least 2.
module sync_byte_fifo
    import host_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_byte_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          wr_ptr_n;
    logic [AW:0]          rd_ptr_n;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_push};
        rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};
    end

    // Flags are computed from the next pointers so they are registered yet
    // never lag the pointer state.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            empty  <= (wr_ptr_n == rd_ptr_n);
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            if (do_pop) begin
                dout <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/host_uart_bridge.sv
// host_uart_bridge: UART 8N1 host link. RXD is deserialised into an RX byte
// FIFO read by the master; bytes written by the master into a TX FIFO are
// serialised onto TXD.
//   CLK, RESETn : clock, synchronous active-low reset
//   RXD         : asynchronous serial input, idles high
//   TXD         : serial output, idles high
//   host        : host-FIFO interface (slave side)
//   RX_OVERFLOW, RX_FRAME_ERR : one-cycle event pulses, present only when
//                 HOST_UART_STATUS_EN is defined
// Parameters: CLK_HZ, BAUD (DIV = CLK_HZ/BAUD must be >= 4), FIFO_DEPTH.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low level
//   RX_START | half a bit into the start bit; high there means a glitch
//   RX_DATA  | sampling 8 data bits, LSB first, one per DIV cycles
//   RX_STOP  | sampling stop bit; after a framing error, waiting for line high
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high; pops the TX FIFO when it has data
//   TX_LOAD  | popped byte is valid; latch it and drive the start bit
//   TX_SHIFT | each frame bit held DIV cycles, stop bit last
module host_uart_bridge
    import host_uart_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 3000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic RXD,
    output logic TXD,
    host_uart_bridge_if.slave host
`ifdef HOST_UART_STATUS_EN
    ,
    output logic RX_OVERFLOW,
    output logic RX_FRAME_ERR
`endif
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BIT_RELOAD  = BW'(DIV - 1);
    localparam logic [BW-1:0] HALF_RELOAD = BW'(DIV / 2 - 1);

    if (DIV < 4) begin : g_bad_div
        $error("host_uart_bridge: CLK_HZ/BAUD must be at least 4");
    end

    // ---------------- RX ----------------
    logic                 rxd_meta;
    logic                 rxd_s;
    rx_state_t            rx_state;
    rx_state_t            rx_state_n;
    logic [BW-1:0]        rx_baud;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_ferr;
    logic                 rx_tick;
    logic                 rx_stop_tick;
    logic                 rx_push;
    logic                 rx_full;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_s    <= rxd_meta;
        end
    end

    assign rx_tick      = (rx_baud == '0);
    assign rx_stop_tick = (rx_state == RX_STOP) && !rx_ferr && rx_tick;
    assign rx_push      = rx_stop_tick && rxd_s && !rx_full;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxd_s) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rxd_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP: begin
                if (rx_ferr) begin
                    if (rxd_s) rx_state_n = RX_IDLE;
                end else if (rx_tick && rxd_s) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= HALF_RELOAD;
                    rx_bit  <= '0;
                    rx_ferr <= 1'b0;
                end
                RX_START: begin
                    rx_baud <= rx_tick ? BIT_RELOAD : rx_baud - 1'b1;
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        rx_baud  <= BIT_RELOAD;
                    end else begin
                        rx_baud <= rx_baud - 1'b1;
                    end
                end
                RX_STOP: begin
                    // A low stop bit latches the error so the FSM parks here
                    // until the line returns high, without re-flagging.
                    if (!rx_ferr) begin
                        if (rx_tick) begin
                            rx_ferr <= ~rxd_s;
                        end else begin
                            rx_baud <= rx_baud - 1'b1;
                        end
                    end
                end
                default: rx_baud <= '0;
            endcase
        end
    end

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK    (CLK),
        .RESETn (RESETn),
        .push   (rx_push),
        .pop    (host.RDEN),
        .din    (rx_shift),
        .dout   (host.RDDATA),
        .empty  (host.RDEMPTY),
        .full   (rx_full)
    );

`ifdef HOST_UART_STATUS_EN
    assign RX_OVERFLOW  = rx_stop_tick & rxd_s & rx_full;
    assign RX_FRAME_ERR = rx_stop_tick & ~rxd_s;
`endif

    // ---------------- TX ----------------
    tx_state_t            tx_state;
    tx_state_t            tx_state_n;
    logic [BW-1:0]        tx_baud;
    logic [3:0]           tx_bit;
    logic [DATA_BITS:0]   tx_shift;
    logic                 tx_tick;
    logic                 tx_pop;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_dout;

    assign tx_tick = (tx_baud == '0);
    assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK    (CLK),
        .RESETn (RESETn),
        .push   (host.WREN),
        .pop    (tx_pop),
        .din    (host.WRDATA),
        .dout   (tx_dout),
        .empty  (tx_empty),
        .full   (host.WRFULL)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_state_n = TX_LOAD;
            TX_LOAD:  tx_state_n = TX_SHIFT;
            TX_SHIFT: if (tx_tick && tx_bit == 4'(FRAME_BITS - 1)) tx_state_n = TX_IDLE;
            default:  tx_state_n = TX_IDLE;
        endcase
    end

    // The start bit is driven directly in TX_LOAD, so the shifter only holds
    // {stop, data}; it back-fills with ones so the stop bit stays high.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            TXD      <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else begin
            case (tx_state)
                TX_LOAD: begin
                    tx_shift <= {1'b1, tx_dout};
                    TXD      <= 1'b0;
                    tx_baud  <= BIT_RELOAD;
                    tx_bit   <= '0;
                end
                TX_SHIFT: begin
                    if (tx_tick) begin
                        TXD      <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[DATA_BITS:1]};
                        tx_bit   <= tx_bit + 4'd1;
                        tx_baud  <= BIT_RELOAD;
                    end else begin
                        tx_baud <= tx_baud - 1'b1;
                    end
                end
                default: TXD <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_host_uart_bridge.sv
// tb_host_uart_bridge: scoreboard bench for host_uart_bridge at DIV=16.
// Stimulus pushes expected bytes into rx_exp / tx_exp; a host-read monitor and
// a TXD line decoder pop and compare. Status pulses are counted when
// HOST_UART_STATUS_EN is defined.
module tb_host_uart_bridge;

    localparam int DIV = 16;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    logic RXD    = 1'b1;
    logic TXD;

    host_uart_bridge_if hif ();

`ifdef HOST_UART_STATUS_EN
    logic rx_ovf;
    logic rx_ferr;
`endif

    host_uart_bridge #(
        .CLK_HZ     (48000000),
        .BAUD       (3000000),
        .FIFO_DEPTH (16)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .RXD    (RXD),
        .TXD    (TXD),
        .host   (hif)
`ifdef HOST_UART_STATUS_EN
        ,
        .RX_OVERFLOW  (rx_ovf),
        .RX_FRAME_ERR (rx_ferr)
`endif
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int         ovf_cnt = 0;
    int         ferr_cnt = 0;
    logic       rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(DIV);
        end
        RXD = stop;
        tick(DIV);
        RXD = 1'b1;
        tick(4);
    endtask

    // Host read monitor: a pop seen in one cycle is checked in the next.
    always @(negedge CLK) begin
        if (rd_pend) begin
            if (rx_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected_pop: got 0x%0h, expected no pop", hif.RDDATA);
            end else begin
                check("rx_byte", {24'd0, hif.RDDATA}, {24'd0, rx_exp.pop_front()});
            end
        end
        rd_pend = RESETn && hif.RDEN && !hif.RDEMPTY;
    end

    // TXD decoder: samples each bit mid-way after the first low cycle.
    initial begin : tx_mon
        logic [7:0] d;
        d = '0;
        forever begin
            @(negedge CLK);
            if (RESETn === 1'b1 && TXD === 1'b0) begin
                repeat (7) @(negedge CLK);
                check("tx_start_mid", {31'd0, TXD}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge CLK);
                    d[i] = TXD;
                end
                repeat (DIV) @(negedge CLK);
                check("tx_stop_mid", {31'd0, TXD}, 32'd1);
                if (tx_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", d);
                end else begin
                    check("tx_byte", {24'd0, d}, {24'd0, tx_exp.pop_front()});
                end
            end
        end
    end

`ifdef HOST_UART_STATUS_EN
    always @(negedge CLK) begin
        if (rx_ovf === 1'b1) ovf_cnt++;
        if (rx_ferr === 1'b1) ferr_cnt++;
    end
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [9:0] fr;
        int         bad;
        hif.RDEN   = 1'b0;
        hif.WREN   = 1'b0;
        hif.WRDATA = 8'h00;

        // Reset with RXD toggling
        for (int i = 0; i < 12; i++) begin
            RXD = i[0];
            tick();
        end
        RXD = 1'b1;
        tick(2);
        @(negedge CLK);
        check("rst_txd",     {31'd0, TXD}, 32'd1);
        check("rst_rdempty", {31'd0, hif.RDEMPTY}, 32'd1);
        check("rst_wrfull",  {31'd0, hif.WRFULL}, 32'd0);
        check("rst_rddata",  {24'd0, hif.RDDATA}, 32'd0);
        @(posedge CLK); #1;

        // Release reset mid-frame (inside the all-ones data bits)
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(60);
                RESETn = 1'b1;
            end
        join
        tick(40);
        @(negedge CLK);
        check("rst_release_no_byte", {31'd0, hif.RDEMPTY}, 32'd1);
        @(posedge CLK); #1;

        // RX 0xA5
        rx_exp.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        @(negedge CLK);
        check("rx_a5_rdempty", {31'd0, hif.RDEMPTY}, 32'd0);
        @(posedge CLK); #1;
        hif.RDEN = 1'b1;
        tick();
        hif.RDEN = 1'b0;
        @(negedge CLK);
        check("rx_a5_empty_after", {31'd0, hif.RDEMPTY}, 32'd1);
        @(posedge CLK); #1;
        hif.RDEN = 1'b1;
        tick();
        hif.RDEN = 1'b0;
        tick();
        @(negedge CLK);
        check("rd_empty_hold", {24'd0, hif.RDDATA}, 32'hA5);
        @(posedge CLK); #1;

        // TX 0x3C exact timing: write in cycle n, start bit from edge ending n+2
        hif.WREN   = 1'b1;
        hif.WRDATA = 8'h3C;
        tx_exp.push_back(8'h3C);
        @(negedge CLK);
        check("tx_idle_n", {31'd0, TXD}, 32'd1);
        @(posedge CLK); #1;
        hif.WREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("tx_pre_start", {31'd0, TXD}, 32'd1);
        @(posedge CLK);
        fr = {1'b1, 8'h3C, 1'b0};
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            repeat (DIV) begin
                @(negedge CLK);
                if (TXD !== fr[b]) bad++;
            end
            check($sformatf("tx_3c_bit%0d", b), bad, 32'd0);
        end
        @(posedge CLK); #1;
        tick(4);

        // TX FIFO full: burst while the transmitter is busy with 0xE7, so no
        // entry is freed during the burst and the 17th byte is dropped.
        hif.WREN   = 1'b1;
        hif.WRDATA = 8'hE7;
        tx_exp.push_back(8'hE7);
        tick();
        hif.WREN = 1'b0;
        tick(20);
        for (int i = 0; i < 17; i++) begin
            hif.WREN   = 1'b1;
            hif.WRDATA = 8'(i);
            if (i < 16) tx_exp.push_back(8'(i));
            tick();
        end
        hif.WREN = 1'b0;
        @(negedge CLK);
        check("tx_full_flag", {31'd0, hif.WRFULL}, 32'd1);
        for (int i = 0; i < 400; i++) begin
            if (hif.WRFULL === 1'b0) break;
            @(negedge CLK);
        end
        check("tx_full_release", {31'd0, hif.WRFULL}, 32'd0);
        for (int i = 0; i < 3500; i++) begin
            if (tx_exp.size() == 0) break;
            @(negedge CLK);
        end
        check("tx_drain", tx_exp.size(), 32'd0);
        tick(20);

        // RX overflow: 17 frames, no reads
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp.push_back(8'(8'h30 + i));
            send_frame(8'(8'h30 + i), 1'b1);
        end
        @(negedge CLK);
        check("rx_ovf_rdempty", {31'd0, hif.RDEMPTY}, 32'd0);
`ifdef HOST_UART_STATUS_EN
        check("rx_ovf_pulse", ovf_cnt, 32'd1);
`endif
        @(posedge CLK); #1;
        hif.RDEN = 1'b1;
        tick(17);
        hif.RDEN = 1'b0;
        tick(2);
        @(negedge CLK);
        check("rx_ovf_drained", rx_exp.size(), 32'd0);
        check("rx_hold_after_drain", {24'd0, hif.RDDATA}, 32'h3F);
        check("rx_ovf_empty", {31'd0, hif.RDEMPTY}, 32'd1);
        @(posedge CLK); #1;

        // Framing error
        send_frame(8'h55, 1'b0);
        tick(20);
        @(negedge CLK);
        check("ferr_no_byte", {31'd0, hif.RDEMPTY}, 32'd1);
`ifdef HOST_UART_STATUS_EN
        check("ferr_pulse", ferr_cnt, 32'd1);
`endif
        @(posedge CLK); #1;

        // Start-bit glitch, then a good frame to show RX is back in idle
        RXD = 1'b0;
        tick(4);
        RXD = 1'b1;
        tick(40);
        @(negedge CLK);
        check("glitch_no_byte", {31'd0, hif.RDEMPTY}, 32'd1);
        @(posedge CLK); #1;
        rx_exp.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        hif.RDEN = 1'b1;
        tick();
        hif.RDEN = 1'b0;
        tick(2);
        @(negedge CLK);
        check("rx_after_glitch", rx_exp.size(), 32'd0);
        @(posedge CLK); #1;

        // Reset flushes a pending RX byte and clears RDDATA
        send_frame(8'h11, 1'b1);
        @(negedge CLK);
        check("flush_pre_rdempty", {31'd0, hif.RDEMPTY}, 32'd0);
        @(posedge CLK); #1;
        RESETn = 1'b0;
        tick(2);
        @(negedge CLK);
        check("rst2_rddata",  {24'd0, hif.RDDATA}, 32'd0);
        check("rst2_rdempty", {31'd0, hif.RDEMPTY}, 32'd1);
        check("rst2_wrfull",  {31'd0, hif.WRFULL}, 32'd0);
        check("rst2_txd",     {31'd0, TXD}, 32'd1);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        tick(4);
`ifdef HOST_UART_STATUS_EN
        check("ovf_total",  ovf_cnt, 32'd1);
        check("ferr_total", ferr_cnt, 32'd1);
`endif
        check("final_rx_queue", rx_exp.size(), 32'd0);
        check("final_tx_queue", tx_exp.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
